// File: rtl/dmem_responder_if.sv
// Data-port bus between a core (master) and the data-memory responder (slave).
interface dmem_responder_if;
    logic        MemReq;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        Ready;
    logic [31:0] ReadData;
    logic        Fault;
    logic        Done;
    logic [31:0] Score;

    modport master (
        output MemReq, MemWrite, DataAdr, WriteData,
        input  Ready, ReadData, Fault, Done, Score
    );

    modport slave (
        input  MemReq, MemWrite, DataAdr, WriteData,
        output Ready, ReadData, Fault, Done, Score
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, fixed wait states, and a
// result mailbox word that latches Score and raises a sticky Done.
// Ready/Fault/ReadData are registered on the edge that ends RESP, so they are
// visible in the cycle after RESP; the write commits on that same edge.
module dmem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT        = 2,
    parameter int MAILBOX_ADR = 252
) (
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (WAIT > 1) ? $clog2(WAIT) : 1;
    localparam logic [CW-1:0] CNT_INIT = (WAIT > 0) ? CW'(WAIT - 1) : CW'(0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          ready_q, ready_d;
    logic          fault_q, fault_d;
    logic          done_q, done_d;
    logic [31:0]   score_q, score_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [31:0]   mem_q [DEPTH];
    logic          mem_we_s;
    logic [29:0]   idx_full_s;
    logic [AW-1:0] mem_idx_s;
    logic          bad_s;
    logic          mbox_s;

    // Decode the latched address: word index, bad-address and mailbox hit.
    always_comb begin
        idx_full_s = adr_q[31:2];
        mem_idx_s  = idx_full_s[AW-1:0];
        bad_s      = (adr_q[1:0] != 2'b00) || (idx_full_s >= 30'(DEPTH));
        mbox_s     = (adr_q == 32'(MAILBOX_ADR));
    end

    // Request FSM, wait counter and response/mailbox next-state logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        adr_d    = adr_q;
        wdata_d  = wdata_q;
        ready_d  = 1'b0;
        fault_d  = 1'b0;
        done_d   = done_q;
        score_d  = score_q;
        rdata_d  = rdata_q;
        mem_we_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.MemReq) begin
                    wr_d    = bus.MemWrite;
                    adr_d   = bus.DataAdr;
                    wdata_d = bus.WriteData;
                    if (WAIT == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (cnt_q == CW'(0)) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                if (bad_s) begin
                    fault_d = 1'b1;
                    rdata_d = 32'd0;
                end else if (wr_q) begin
                    mem_we_s = 1'b1;
                    if (mbox_s) begin
                        score_d = wdata_q;
                        done_d  = 1'b1;
                    end else begin
                        score_d = score_q;
                    end
                end else begin
                    rdata_d = mem_q[mem_idx_s];
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and output registers; reset discards any in-flight request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= CW'(0);
            wr_q    <= 1'b0;
            adr_q   <= 32'd0;
            wdata_q <= 32'd0;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
            done_q  <= 1'b0;
            score_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            adr_q   <= adr_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            fault_q <= fault_d;
            done_q  <= done_d;
            score_q <= score_d;
            rdata_q <= rdata_d;
        end
    end

    // Memory array: not cleared by reset, and a reset on the RESP edge blocks the write.
    always_ff @(posedge clk) begin
        if (!reset && mem_we_s) begin
            mem_q[mem_idx_s] <= wdata_q;
        end
    end

    assign bus.Ready    = ready_q;
    assign bus.Fault    = fault_q;
    assign bus.Done     = done_q;
    assign bus.Score    = score_q;
    assign bus.ReadData = rdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: WAIT=2 instance (a) and WAIT=0 instance (b) on a shared
// clock/reset; a reference model pushes expected responses to a scoreboard.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        req [2];
    logic        wr  [2];
    logic [31:0] adr [2];
    logic [31:0] wd  [2];

    dmem_responder_if if_a ();
    dmem_responder_if if_b ();

    assign if_a.MemReq = req[0];  assign if_a.MemWrite = wr[0];
    assign if_a.DataAdr = adr[0]; assign if_a.WriteData = wd[0];
    assign if_b.MemReq = req[1];  assign if_b.MemWrite = wr[1];
    assign if_b.DataAdr = adr[1]; assign if_b.WriteData = wd[1];

    dmem_responder #(.DEPTH(64), .WAIT(2), .MAILBOX_ADR(252)) dut_a (
        .clk(clk), .reset(reset), .bus(if_a.slave));
    dmem_responder #(.DEPTH(64), .WAIT(0), .MAILBOX_ADR(252)) dut_b (
        .clk(clk), .reset(reset), .bus(if_b.slave));

    typedef struct packed {
        logic [31:0] rd;
        logic        flt;
        logic        done;
        logic [31:0] score;
        logic [7:0]  lat;
        logic        drop;
    } resp_t;

    resp_t sb [$];
    int checks = 0;
    int errors = 0;

    logic [31:0] mdl_mem [2][64];
    logic [31:0] mdl_rd [2];
    logic [31:0] mdl_score [2];
    logic        mdl_done [2];

    function automatic logic get_ready(input bit sel);
        return sel ? if_b.Ready : if_a.Ready;
    endfunction

    function automatic resp_t sample_out(input bit sel);
        resp_t r;
        r = '0;
        r.rd    = sel ? if_b.ReadData : if_a.ReadData;
        r.flt   = sel ? if_b.Fault : if_a.Fault;
        r.done  = sel ? if_b.Done : if_a.Done;
        r.score = sel ? if_b.Score : if_a.Score;
        return r;
    endfunction

    // Reference model: compute the response for a request and queue it.
    function automatic void model_push(input bit sel, input bit w, input logic [31:0] a, input logic [31:0] d);
        resp_t e;
        logic bad;
        bad = (a[1:0] != 2'b00) || (a[31:2] >= 30'd64);
        if (bad) begin
            mdl_rd[sel] = 32'd0;
        end else if (w) begin
            mdl_mem[sel][a[7:2]] = d;
            if (a == 32'd252) begin
                mdl_score[sel] = d;
                mdl_done[sel]  = 1'b1;
            end
        end else begin
            mdl_rd[sel] = mdl_mem[sel][a[7:2]];
        end
        e.rd = mdl_rd[sel]; e.flt = bad; e.done = mdl_done[sel]; e.score = mdl_score[sel];
        e.lat = sel ? 8'd1 : 8'd3; e.drop = 1'b1;
        sb.push_back(e);
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < 2; s++) begin
            mdl_rd[s] = 32'd0; mdl_score[s] = 32'd0; mdl_done[s] = 1'b0;
        end
    endfunction

    // Monitor: wait (bounded) for Ready, capture outputs, then confirm Ready drops.
    task automatic wait_resp(input bit sel, output resp_t act);
        act = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (get_ready(sel) === 1'b1) begin
                act = sample_out(sel);
                act.lat = 8'(i);
                break;
            end
        end
        @(negedge clk);
        act.drop = (get_ready(sel) === 1'b0);
    endtask

    task automatic transact(input bit sel, input bit w, input logic [31:0] a, input logic [31:0] d,
                            output resp_t e, output resp_t act);
        model_push(sel, w, a, d);
        @(negedge clk);
        req[sel] = 1'b1; wr[sel] = w; adr[sel] = a; wd[sel] = d;
        @(negedge clk);
        req[sel] = 1'b0;
        wait_resp(sel, act);
        e = sb.pop_front();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();
        for (int s = 0; s < 2; s++) begin
            resp_t r;
            r = sample_out(s[0]);
            checks++;
            if ({get_ready(s[0]), r} !== '0) begin
                errors++;
                $display("FAIL reset_%0d: got ready=%0d rd=%h flt=%0d done=%0d score=%h, want all 0",
                         s, get_ready(s[0]), r.rd, r.flt, r.done, r.score);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_read_write();
        logic [64:0] ops [9];
        resp_t e, a;
        ops = '{{1'b1, 32'h10, 32'hDEADBEEF}, {1'b0, 32'h10, 32'h0}, {1'b1, 32'h0, 32'h01234567},
                {1'b1, 32'hF8, 32'h0BADF00D}, {1'b1, 32'h20, 32'h0000AAAA}, {1'b1, 32'h30, 32'h00005A5A},
                {1'b1, 32'h24, 32'h0}, {1'b0, 32'hF8, 32'h0}, {1'b0, 32'h0, 32'h0}};
        for (int i = 0; i < 9; i++) begin
            transact(1'b0, ops[i][64], ops[i][63:32], ops[i][31:0], e, a);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL rw_%0d: got rd=%h flt=%0d done=%0d score=%h lat=%0d drop=%0d, want rd=%h flt=%0d done=%0d score=%h lat=%0d drop=%0d",
                         i, a.rd, a.flt, a.done, a.score, a.lat, a.drop, e.rd, e.flt, e.done, e.score, e.lat, e.drop);
            end
        end
    endtask

    task automatic test_mailbox();
        logic [64:0] ops [5];
        resp_t e, a;
        ops = '{{1'b1, 32'd252, 32'd22}, {1'b1, 32'd252, 32'd7}, {1'b0, 32'd252, 32'h0},
                {1'b1, 32'hFE, 32'h66}, {1'b0, 32'h10, 32'h0}};
        for (int i = 0; i < 5; i++) begin
            transact(1'b0, ops[i][64], ops[i][63:32], ops[i][31:0], e, a);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL mailbox_%0d: got rd=%h flt=%0d done=%0d score=%h lat=%0d, want rd=%h flt=%0d done=%0d score=%h lat=%0d",
                         i, a.rd, a.flt, a.done, a.score, a.lat, e.rd, e.flt, e.done, e.score, e.lat);
            end
        end
    endtask

    task automatic test_bad_address();
        logic [64:0] ops [8];
        resp_t e, a;
        ops = '{{1'b1, 32'h12, 32'h55}, {1'b0, 32'h10, 32'h0}, {1'b0, 32'hF8, 32'h0},
                {1'b0, 32'h100, 32'h0}, {1'b0, 32'h400, 32'h0}, {1'b0, 32'h11, 32'h0},
                {1'b1, 32'h100, 32'h77}, {1'b0, 32'h0, 32'h0}};
        for (int i = 0; i < 8; i++) begin
            transact(1'b0, ops[i][64], ops[i][63:32], ops[i][31:0], e, a);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL bad_adr_%0d: got rd=%h flt=%0d done=%0d score=%h lat=%0d, want rd=%h flt=%0d done=%0d score=%h lat=%0d",
                         i, a.rd, a.flt, a.done, a.score, a.lat, e.rd, e.flt, e.done, e.score, e.lat);
            end
        end
    endtask

    task automatic test_ignored_request();
        resp_t e, a;
        int pulses = 0;
        a = '0;
        model_push(1'b0, 1'b1, 32'h24, 32'h11);
        @(negedge clk);
        req[0] = 1'b1; wr[0] = 1'b1; adr[0] = 32'h24; wd[0] = 32'h11;
        @(negedge clk);
        adr[0] = 32'h20; wd[0] = 32'h99;
        @(negedge clk);
        req[0] = 1'b0;
        for (int i = 2; i < 12; i++) begin
            @(negedge clk);
            if (get_ready(1'b0) === 1'b1) begin
                pulses++;
                a = sample_out(1'b0);
                a.lat = 8'(i);
            end
        end
        e = sb.pop_front();
        checks++;
        if (pulses !== 1 || a.rd !== e.rd || a.lat !== e.lat || a.flt !== e.flt) begin
            errors++;
            $display("FAIL ignored_req: got pulses=%0d rd=%h lat=%0d flt=%0d, want pulses=1 rd=%h lat=%0d flt=%0d",
                     pulses, a.rd, a.lat, a.flt, e.rd, e.lat, e.flt);
        end
        transact(1'b0, 1'b0, 32'h20, 32'h0, e, a);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL ignored_readback: got rd=%h lat=%0d, want rd=%h lat=%0d", a.rd, a.lat, e.rd, e.lat);
        end
    endtask

    task automatic test_reset_mid_op();
        resp_t e, a;
        int pulses = 0;
        // Reset while BUSY, then a request on the very first post-reset cycle.
        @(negedge clk);
        req[0] = 1'b1; wr[0] = 1'b1; adr[0] = 32'h30; wd[0] = 32'h1234;
        @(negedge clk);
        req[0] = 1'b0; reset = 1'b1;
        @(negedge clk);
        if (get_ready(1'b0) === 1'b1) pulses++;
        model_reset();
        reset = 1'b0; req[0] = 1'b1; wr[0] = 1'b0; adr[0] = 32'h30; wd[0] = 32'h0;
        model_push(1'b0, 1'b0, 32'h30, 32'h0);
        @(negedge clk);
        req[0] = 1'b0;
        if (get_ready(1'b0) === 1'b1) pulses++;
        wait_resp(1'b0, a);
        e = sb.pop_front();
        checks++;
        if (pulses !== 0 || a !== e) begin
            errors++;
            $display("FAIL reset_busy: got pulses=%0d rd=%h lat=%0d done=%0d, want pulses=0 rd=%h lat=%0d done=%0d",
                     pulses, a.rd, a.lat, a.done, e.rd, e.lat, e.done);
        end
        // Reset coinciding with the edge that ends RESP: no write, no Ready.
        @(negedge clk);
        req[0] = 1'b1; wr[0] = 1'b1; adr[0] = 32'h30; wd[0] = 32'h4321;
        @(negedge clk);
        req[0] = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (get_ready(1'b0) !== 1'b0 || if_a.Fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp_edge: got ready=%0d fault=%0d, want 0 0", get_ready(1'b0), if_a.Fault);
        end
        reset = 1'b0;
        model_reset();
        transact(1'b0, 1'b0, 32'h30, 32'h0, e, a);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL reset_resp_readback: got rd=%h lat=%0d, want rd=%h lat=%0d", a.rd, a.lat, e.rd, e.lat);
        end
    endtask

    task automatic test_wait0();
        logic [64:0] ops [4];
        resp_t e, a;
        ops = '{{1'b1, 32'h8, 32'h0000CAFE}, {1'b0, 32'h8, 32'h0}, {1'b0, 32'h400, 32'h0},
                {1'b1, 32'd252, 32'd3}};
        for (int i = 0; i < 4; i++) begin
            transact(1'b1, ops[i][64], ops[i][63:32], ops[i][31:0], e, a);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL wait0_%0d: got rd=%h flt=%0d done=%0d score=%h lat=%0d drop=%0d, want rd=%h flt=%0d done=%0d score=%h lat=%0d drop=%0d",
                         i, a.rd, a.flt, a.done, a.score, a.lat, a.drop, e.rd, e.flt, e.done, e.score, e.lat, e.drop);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pat = 8'h00;
        @(negedge clk);
        req[1] = 1'b1; wr[1] = 1'b0; adr[1] = 32'h8; wd[1] = 32'h0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pat[i] = (get_ready(1'b1) === 1'b1);
        end
        req[1] = 1'b0;
        checks++;
        if (pat !== 8'hAA || if_b.ReadData !== 32'h0000CAFE) begin
            errors++;
            $display("FAIL back_to_back: got ready_pattern=%b rd=%h, want ready_pattern=10101010 rd=0000cafe",
                     pat, if_b.ReadData);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            req[s] = 1'b0; wr[s] = 1'b0; adr[s] = 32'd0; wd[s] = 32'd0;
        end
        test_reset();
        test_read_write();
        test_mailbox();
        test_bad_address();
        test_ignored_request();
        test_reset_mid_op();
        test_wait0();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
